// File: rtl/fib14_env_driver.sv
// Stimulus driver and cycle-exact shadow checker for the fib_14 counter.
// Drives selector from a pattern source and flags model/invariant errors.
module fib14_env_driver #(
    parameter int          W        = 11,
    parameter int          M_INIT   = 300,
    parameter int          RUN_LEN  = 512,
    parameter logic [15:0] SEED_DEF = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [15:0]  seed,
    output logic         selector,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] j_in,
    input  logic [W-1:0] m_in,
    output logic         busy,
    output logic         done,
    output logic         mismatch,
    output logic         viol,
    output logic [15:0]  err_cycle,
    output logic [9:0]   ones_cnt
);

    localparam int          RW  = $clog2(RUN_LEN + 1);
    localparam logic [W-1:0] MI = W'(M_INIT);
    localparam logic [RW-1:0] RL = RW'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          phase_q, phase_d;
    logic [RW-1:0] run_q, run_d;
    logic [9:0]    ones_q, ones_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_j_q, sh_j_d;
    logic [15:0]   cyc_q;
    logic          mis_q, mis_d;
    logic          viol_q, viol_d;
    logic [15:0]   errc_q, errc_d;

    logic          pat;
    logic          fb;
    logic          sat;
    logic [RW-1:0] run_nx;
    logic          mis_now;
    logic          vio_now;
    logic [W:0]    m_p1;

    assign fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign sat    = sh_j_q > MI;
    assign run_nx = run_q + RW'(1);
    assign m_p1   = {1'b0, m_in} + (W+1)'(1);

    assign mis_now = (a_in != sh_a_q) || (j_in != sh_j_q) || (m_in != MI);
    assign vio_now = (a_in >= j_in) || ({1'b0, j_in} > m_p1) || (m_in != MI);

    always_comb begin
        pat = 1'b0;
        unique case (mode)
            2'd0: pat = lfsr_q[0];
            2'd1: pat = 1'b1;
            2'd2: pat = 1'b0;
            2'd3: pat = phase_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        lfsr_d  = lfsr_q;
        phase_d = phase_q;
        run_d   = run_q;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE: begin
                sel_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = (seed == 16'd0) ? SEED_DEF : seed;
                    ones_d  = '0;
                    run_d   = '0;
                    phase_d = 1'b1;
                end
            end
            RUN: begin
                // A saturated counter ends the run before anything else is driven
                if (sat) begin
                    sel_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    sel_d   = pat;
                    lfsr_d  = {fb, lfsr_q[15:1]};
                    phase_d = ~phase_q;
                    run_d   = run_nx;
                    if (pat && ones_q != 10'h3FF) begin
                        ones_d = ones_q + 10'd1;
                    end
                    if (run_nx == RL) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                sel_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sh_a_d = sh_a_q;
        sh_j_d = sh_j_q;
        if (sel_q && sh_j_q <= MI) begin
            sh_a_d = sh_a_q + W'(1);
            sh_j_d = sh_j_q + W'(1);
        end else if (!sel_q && sh_j_q <= MI && sh_a_q != '0) begin
            sh_a_d = sh_a_q - W'(1);
            sh_j_d = sh_j_q + W'(1);
        end
    end

    always_comb begin
        mis_d  = mis_q | mis_now;
        viol_d = viol_q | vio_now;
        errc_d = errc_q;
        // Only the first error of either kind is timestamped
        if (!mis_q && !viol_q && (mis_now || vio_now)) begin
            errc_d = cyc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            lfsr_q  <= SEED_DEF;
            phase_q <= 1'b0;
            run_q   <= '0;
            ones_q  <= '0;
            sh_a_q  <= '0;
            sh_j_q  <= W'(1);
            cyc_q   <= '0;
            mis_q   <= 1'b0;
            viol_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            lfsr_q  <= lfsr_d;
            phase_q <= phase_d;
            run_q   <= run_d;
            ones_q  <= ones_d;
            sh_a_q  <= sh_a_d;
            sh_j_q  <= sh_j_d;
            cyc_q   <= cyc_q + 16'd1;
            mis_q   <= mis_d;
            viol_q  <= viol_d;
            errc_q  <= errc_d;
        end
    end

    assign selector  = sel_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign mismatch  = mis_q;
    assign viol      = viol_q;
    assign err_cycle = errc_q;
    assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_fib14_env_driver.sv
// Directed bench for fib14_env_driver with a behavioural fib_14 counter
// closing the loop on selector; a_in can be perturbed to inject errors.
module tb_fib14_env_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] seed = 16'd0;
    logic        selector;
    logic [10:0] a_in;
    logic [10:0] j_in;
    logic [10:0] m_in;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic        viol;
    logic [15:0] err_cycle;
    logic [9:0]  ones_cnt;

    logic [10:0] ca;
    logic [10:0] cj;
    logic        inj = 1'b0;
    logic [15:0] seq;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Counter under observation
    always @(posedge clk) begin
        if (rst) begin
            ca <= 11'd0;
            cj <= 11'd1;
        end else if (selector && cj <= 11'd300) begin
            ca <= ca + 11'd1;
            cj <= cj + 11'd1;
        end else if (!selector && cj <= 11'd300 && ca != 11'd0) begin
            ca <= ca - 11'd1;
            cj <= cj + 11'd1;
        end
    end

    assign a_in = ca + {10'd0, inj};
    assign j_in = cj;
    assign m_in = 11'd300;

    fib14_env_driver dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .selector  (selector),
        .a_in      (a_in),
        .j_in      (j_in),
        .m_in      (m_in),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .viol      (viol),
        .err_cycle (err_cycle),
        .ones_cnt  (ones_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic collect(output logic [15:0] s);
        s = '0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            s[i] = selector;
        end
    endtask

    initial begin
        tick(2);
        check("rst_sel", 32'(selector), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mis", 32'(mismatch), 0);
        check("rst_viol", 32'(viol), 0);
        check("rst_errc", 32'(err_cycle), 0);
        check("rst_ones", 32'(ones_cnt), 0);
        rst = 1'b0;

        // idle, no start
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check("idle_sel", 32'(selector), 0);
        end
        check("idle_a", 32'(ca), 0);
        check("idle_j", 32'(cj), 1);
        check("idle_mis", 32'(mismatch), 0);
        check("idle_viol", 32'(viol), 0);

        // error injection at cycle 40
        do_reset();
        tick(40);
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        check("inj_mis", 32'(mismatch), 1);
        check("inj_viol", 32'(viol), 1);
        check("inj_errc", 32'(err_cycle), 40);
        tick(5);
        inj = 1'b1;
        tick(1);
        inj = 1'b0;
        tick(2);
        check("inj_mis_hold", 32'(mismatch), 1);
        check("inj_viol_hold", 32'(viol), 1);
        check("inj_errc_hold", 32'(err_cycle), 40);

        // all-ones run to saturation
        do_reset();
        mode = 2'd1;
        tick(2);
        go();
        tick(301);
        check("m1_a", 32'(ca), 300);
        check("m1_j", 32'(cj), 301);
        check("m1_ones", 32'(ones_cnt), 301);
        check("m1_busy", 32'(busy), 1);
        check("m1_done0", 32'(done), 0);
        tick(1);
        check("m1_done", 32'(done), 1);
        check("m1_busy_d", 32'(busy), 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("m1_done_end", 32'(done), 0);
        check("m1_start_ign", 32'(busy), 0);
        check("m1_ones_hold", 32'(ones_cnt), 301);
        check("m1_mis", 32'(mismatch), 0);
        check("m1_viol", 32'(viol), 0);

        // alternating pattern
        do_reset();
        mode = 2'd3;
        go();
        tick(10);
        check("m3_a10", 32'(ca), 1);
        check("m3_j10", 32'(cj), 10);
        check("m3_ones10", 32'(ones_cnt), 5);
        tick(1);
        check("m3_a11", 32'(ca), 0);
        check("m3_j11", 32'(cj), 11);
        check("m3_ones11", 32'(ones_cnt), 6);
        check("m3_mis", 32'(mismatch), 0);

        // all-zeros, run-length exit
        do_reset();
        mode = 2'd2;
        go();
        tick(511);
        check("m2_busy", 32'(busy), 1);
        check("m2_done0", 32'(done), 0);
        tick(1);
        check("m2_done", 32'(done), 1);
        check("m2_ones", 32'(ones_cnt), 0);
        check("m2_a", 32'(ca), 0);
        check("m2_j", 32'(cj), 1);
        tick(1);
        check("m2_done_end", 32'(done), 0);
        check("m2_idle", 32'(busy), 0);

        // LFSR with default seed, reset mid-run
        do_reset();
        mode = 2'd0;
        seed = 16'd0;
        go();
        collect(seq);
        check("lfsr_seq1", 32'(seq), 32'hACE1);
        tick(84);
        rst = 1'b1;
        tick(1);
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_sel", 32'(selector), 0);
        check("mid_a", 32'(ca), 0);
        check("mid_j", 32'(cj), 1);
        check("mid_ones", 32'(ones_cnt), 0);
        check("mid_mis", 32'(mismatch), 0);
        rst = 1'b0;
        go();
        collect(seq);
        check("lfsr_seq2", 32'(seq), 32'hACE1);
        check("lfsr_mis", 32'(mismatch), 0);
        check("lfsr_viol", 32'(viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
